bus_arb2: RTL and testbench
===========================

BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 Parameter RESP_TIMEOUT, default 1024: cycles in WAIT_RESP before a read is force-completed (timeout feature only).
REQ-002 clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 mN_req_i  input  1  master N (N=0,1) request, held until ack.
REQ-005 mN_we_i  input  1  master N write (1) / read (0).
REQ-006 mN_addr_bi  input  32  master N byte address.
REQ-007 mN_be_bi  input  4  master N byte enables.
REQ-008 mN_wdata_bi  input  32  master N write data.
REQ-009 mN_ack_o  output  1  master N request accepted.
REQ-010 mN_resp_o  output  1  master N read response valid, one cycle.
REQ-011 mN_rdata_bo  output  32  master N read data, valid with mN_resp_o.
REQ-012 s_req_o, s_we_o, s_addr_bo[32], s_be_bo[4], s_wdata_bo[32]  output  slave request channel.
REQ-013 s_ack_i  input  1  slave accepted request.
REQ-014 s_resp_i  input  1  slave read response valid.
REQ-015 s_rdata_bi  input  32  slave read data.
REQ-016 err_o  output  1  one-cycle pulse on read timeout.

Function
REQ-017 Three states SHALL exist: IDLE, REQ, WAIT_RESP; one transaction outstanding at most.
REQ-018 IDLE: if any mN_req_i is high, latch sel and go to REQ next cycle; s_req_o SHALL be 0 in IDLE (1-cycle grant latency).
REQ-019 Both requests high in IDLE: grant the master not granted last (round-robin); a single requester SHALL be granted regardless of history.
REQ-020 REQ: s_req_o = m[sel]_req_i; s_we_o, s_addr_bo, s_be_bo, s_wdata_bo SHALL be combinational copies of m[sel] fields.
REQ-021 m[sel]_ack_o = s_ack_i in REQ; the other master's ack, and all acks outside REQ, SHALL be 0.
REQ-022 REQ with s_ack_i=1: write -> IDLE; read -> WAIT_RESP; last-granted updated to sel.
REQ-023 REQ with m[sel]_req_i=0 (protocol violation) -> IDLE, no ack, last-granted unchanged.
REQ-024 WAIT_RESP: m[sel]_resp_o = s_resp_i and m[sel]_rdata_bo = s_rdata_bi (zero latency); on s_resp_i -> IDLE.
REQ-025 s_resp_i outside WAIT_RESP SHALL be ignored; non-selected mN_resp_o SHALL be 0, its mN_rdata_bo 0.
REQ-026 Slave field outputs SHALL be 0 when s_req_o is 0.
REQ-027 A new master request SHALL NOT be forwarded before the current transaction returns to IDLE.

Reset
REQ-028 rst_i high SHALL immediately force IDLE, sel=0, last-granted=1 (master 0 wins first tie), timeout counter 0.
REQ-029 During and after reset, all outputs SHALL be 0 combinationally; an in-flight transaction is abandoned, no ack/resp generated.

Configuration
REQ-030 Macro BUS_ARB2_TIMEOUT_EN defined: a counter clears on WAIT_RESP entry, increments each cycle without s_resp_i; at RESP_TIMEOUT, m[sel]_resp_o=1 with rdata 32'hFFFFFFFF, err_o=1 for that cycle, -> IDLE.
REQ-031 Macro undefined: no counter, WAIT_RESP waits indefinitely, err_o tied 0.

Verification
REQ-032 m0 write addr 32'h0 data 32'h00A5 alone -> s_req_o one cycle after m0_req_i, fields match, m0_ack_o with s_ack_i, back to IDLE, m1 signals 0.
REQ-033 m1 read 32'h80000004, slave resp 2 cycles after ack with 32'h12345678 -> m1_resp_o one cycle, m1_rdata_bo 32'h12345678, m0_resp_o 0.
REQ-034 m0 and m1 both request continuously (writes, immediate ack) from reset -> grants alternate m0, m1, m0, m1.
REQ-035 BUS_ARB2_TIMEOUT_EN, RESP_TIMEOUT=8, read with no s_resp_i -> m[sel]_resp_o with 32'hFFFFFFFF and err_o after 8 WAIT_RESP cycles; without macro, still waiting after 100 cycles.
REQ-036 rst_i asserted in WAIT_RESP, then s_resp_i pulsed after release -> no mN_resp_o, state IDLE, next tie granted to m0.

Source files
------------

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter onto a single slave request/response channel.
// Optional read-response timeout enabled by defining BUS_ARB2_TIMEOUT_EN.
module bus_arb2 #(
   parameter int unsigned RESP_TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_bi,
   input  logic [3:0]  m0_be_bi,
   input  logic [31:0] m0_wdata_bi,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_bo,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_bi,
   input  logic [3:0]  m1_be_bi,
   input  logic [31:0] m1_wdata_bi,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_bo,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_bo,
   output logic [3:0]  s_be_bo,
   output logic [31:0] s_wdata_bo,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_bi,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

   state_t state_q, state_d;
   logic   sel_q, sel_d;
   logic   last_q, last_d;

   logic        sel_req;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [3:0]  sel_be;
   logic [31:0] sel_wdata;
   logic        timeout;
   logic        resp_v;
   logic [31:0] rdata_v;

   assign sel_req   = sel_q ? m1_req_i    : m0_req_i;
   assign sel_we    = sel_q ? m1_we_i     : m0_we_i;
   assign sel_addr  = sel_q ? m1_addr_bi  : m0_addr_bi;
   assign sel_be    = sel_q ? m1_be_bi    : m0_be_bi;
   assign sel_wdata = sel_q ? m1_wdata_bi : m0_wdata_bi;

`ifdef BUS_ARB2_TIMEOUT_EN
   localparam int CW = $clog2(RESP_TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // Fires once RESP_TIMEOUT full cycles have elapsed in WAIT_RESP without a response.
   assign timeout = (state_q == WAIT_RESP) && (cnt_q == CW'(RESP_TIMEOUT));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
`ifdef BUS_ARB2_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
`ifdef BUS_ARB2_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
`ifdef BUS_ARB2_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      s_req_o     = 1'b0;
      s_we_o      = 1'b0;
      s_addr_bo   = '0;
      s_be_bo     = '0;
      s_wdata_bo  = '0;
      m0_ack_o    = 1'b0;
      m1_ack_o    = 1'b0;
      m0_resp_o   = 1'b0;
      m1_resp_o   = 1'b0;
      m0_rdata_bo = '0;
      m1_rdata_bo = '0;
      err_o       = 1'b0;
      resp_v      = 1'b0;
      rdata_v     = '0;

      case (state_q)
         IDLE: begin
            if (m0_req_i || m1_req_i) begin
               state_d = REQ;
               sel_d   = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
            end
         end
         REQ: begin
            if (sel_req) begin
               s_req_o    = 1'b1;
               s_we_o     = sel_we;
               s_addr_bo  = sel_addr;
               s_be_bo    = sel_be;
               s_wdata_bo = sel_wdata;
               m0_ack_o   = !sel_q && s_ack_i;
               m1_ack_o   = sel_q && s_ack_i;
               if (s_ack_i) begin
                  last_d  = sel_q;
                  state_d = sel_we ? IDLE : WAIT_RESP;
`ifdef BUS_ARB2_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end else begin
               // Master withdrew before acceptance: abandon without touching history.
               state_d = IDLE;
            end
         end
         WAIT_RESP: begin
            resp_v  = s_resp_i || timeout;
            rdata_v = s_resp_i ? s_rdata_bi : (timeout ? 32'hFFFF_FFFF : s_rdata_bi);
            if (sel_q) begin
               m1_resp_o   = resp_v;
               m1_rdata_bo = rdata_v;
            end else begin
               m0_resp_o   = resp_v;
               m0_rdata_bo = rdata_v;
            end
            if (s_resp_i) begin
               state_d = IDLE;
            end else if (timeout) begin
               err_o   = 1'b1;
               state_d = IDLE;
            end else begin
`ifdef BUS_ARB2_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed self-checking bench for bus_arb2 (RESP_TIMEOUT overridden to 8).
`timescale 1ns/1ps
module tb_bus_arb2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        m0_req_i = 0, m0_we_i = 0;
   logic [31:0] m0_addr_bi = 0, m0_wdata_bi = 0;
   logic [3:0]  m0_be_bi = 0;
   logic        m0_ack_o, m0_resp_o;
   logic [31:0] m0_rdata_bo;
   logic        m1_req_i = 0, m1_we_i = 0;
   logic [31:0] m1_addr_bi = 0, m1_wdata_bi = 0;
   logic [3:0]  m1_be_bi = 0;
   logic        m1_ack_o, m1_resp_o;
   logic [31:0] m1_rdata_bo;
   logic        s_req_o, s_we_o;
   logic [31:0] s_addr_bo, s_wdata_bo;
   logic [3:0]  s_be_bo;
   logic        s_ack_i = 0, s_resp_i = 0;
   logic [31:0] s_rdata_bi = 0;
   logic        err_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   bus_arb2 #(.RESP_TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
      .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi),
      .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
      .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi),
      .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
      .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
      .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
      .err_o(err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
   endtask

   int grants;
   int exp_sel;
   int hit_idx;
   logic [31:0] hit_rdata;
   logic hit_err;
   logic seen_resp;

   initial begin
      // Reset state
      tick();
      check("rst_sreq", s_req_o, 0);
      check("rst_acks", {m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o}, 0);
      check("rst_err", err_o, 0);
      rst_i = 1'b0;
      tick();

      // m0 single write
      m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h0; m0_wdata_bi = 32'h00A5; m0_be_bi = 4'hF;
      #1 check("wr_idle_sreq", s_req_o, 0);
      tick();
      check("wr_sreq", s_req_o, 1);
      check("wr_we", s_we_o, 1);
      check("wr_addr", s_addr_bo, 32'h0);
      check("wr_wdata", s_wdata_bo, 32'h00A5);
      check("wr_be", s_be_bo, 4'hF);
      check("wr_ack_noslave", m0_ack_o, 0);
      s_ack_i = 1;
      #1 check("wr_m0ack", m0_ack_o, 1);
      check("wr_m1ack", m1_ack_o, 0);
      tick();
      m0_req_i = 0; s_ack_i = 0;
      #1 check("wr_back_idle", {s_req_o, s_addr_bo}, 0);
      $display("txn m0 write addr=%h data=%h", 32'h0, 32'h00A5);

      // Response outside WAIT_RESP ignored
      s_resp_i = 1; s_rdata_bi = 32'hDEADBEEF;
      #1 check("idle_resp_ignored", {m0_resp_o, m1_resp_o, m0_rdata_bo[0], m1_rdata_bo[0]}, 0);
      s_resp_i = 0; s_rdata_bi = 0;

      // m1 single read
      m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h8000_0004; m1_be_bi = 4'hF;
      tick();
      check("rd_sreq", s_req_o, 1);
      check("rd_we", s_we_o, 0);
      check("rd_addr", s_addr_bo, 32'h8000_0004);
      s_ack_i = 1;
      #1 check("rd_m1ack", {m0_ack_o, m1_ack_o}, 2'b01);
      tick();
      m1_req_i = 0; s_ack_i = 0;
      m0_req_i = 1; m0_we_i = 1;
      #1 check("rd_wait_noresp", m1_resp_o, 0);
      check("rd_no_forward", s_req_o, 0);
      tick();
      s_resp_i = 1; s_rdata_bi = 32'h1234_5678;
      #1 check("rd_m1resp", m1_resp_o, 1);
      check("rd_m1rdata", m1_rdata_bo, 32'h1234_5678);
      check("rd_m0quiet", {m0_resp_o, m0_rdata_bo}, 0);
      tick();
      s_resp_i = 0; s_rdata_bi = 0; m0_req_i = 0;
      #1 check("rd_resp_oneshot", m1_resp_o, 0);
      $display("txn m1 read addr=%h rdata=%h", 32'h8000_0004, 32'h1234_5678);
      tick(); tick();

      // Round-robin from reset, both writing, slave always accepting
      do_reset();
      m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h100;
      m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h200;
      s_ack_i = 1;
      grants = 0; exp_sel = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s_req_o) begin
            check("rr_grant", {m1_ack_o, m0_ack_o}, (exp_sel == 0) ? 2'b01 : 2'b10);
            check("rr_addr", s_addr_bo, (exp_sel == 0) ? 32'h100 : 32'h200);
            $display("txn rr grant %0d to m%0d", grants, exp_sel);
            grants++;
            exp_sel = 1 - exp_sel;
         end
      end
      check("rr_count", grants, 4);
      m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;
      tick(); tick();

      // Read with no response: timeout or indefinite wait
      do_reset();
      m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h40;
      tick();
      s_ack_i = 1;
      tick();
      m0_req_i = 0; s_ack_i = 0;
      hit_idx = 0; seen_resp = 0; hit_rdata = 0; hit_err = 0;
`ifdef BUS_ARB2_TIMEOUT_EN
      for (int i = 1; i <= 20; i++) begin
         #1;
         if (m0_resp_o && !seen_resp) begin
            seen_resp = 1; hit_idx = i; hit_rdata = m0_rdata_bo; hit_err = err_o;
         end
         tick();
      end
      check("to_cycle", hit_idx, 9);
      check("to_rdata", hit_rdata, 32'hFFFF_FFFF);
      check("to_err", hit_err, 1);
      check("to_err_oneshot", err_o, 0);
      $display("txn m0 read timeout at wait cycle %0d", hit_idx);
`else
      for (int i = 1; i <= 100; i++) begin
         #1;
         if (m0_resp_o || err_o) seen_resp = 1;
         tick();
      end
      check("nto_no_resp", seen_resp, 0);
      s_resp_i = 1; s_rdata_bi = 32'hCAFE_F00D;
      #1 check("nto_still_waiting", m0_resp_o, 1);
      check("nto_rdata", m0_rdata_bo, 32'hCAFE_F00D);
      tick();
      s_resp_i = 0; s_rdata_bi = 0;
      $display("txn m0 read still waiting after 100 cycles, then completed");
`endif
      tick();

      // Reset during WAIT_RESP abandons the read
      m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h44;
      tick();
      s_ack_i = 1;
      tick();
      m1_req_i = 0; s_ack_i = 0;
      tick();
      #2 rst_i = 1; s_resp_i = 1; s_rdata_bi = 32'h5555_AAAA;
      #1 check("rstw_outputs", {m0_resp_o, m1_resp_o, m0_ack_o, m1_ack_o, s_req_o, err_o}, 0);
      check("rstw_rdata", m1_rdata_bo, 0);
      s_resp_i = 0;
      tick(); tick();
      rst_i = 0;
      tick();
      s_resp_i = 1;
      #1 check("rstw_resp_ignored", {m0_resp_o, m1_resp_o}, 0);
      tick();
      s_resp_i = 0; s_rdata_bi = 0;
      m0_req_i = 1; m0_we_i = 1; m1_req_i = 1; m1_we_i = 1;
      tick();
      check("rstw_tie_m0", {s_req_o, m1_ack_o, m0_ack_o, s_addr_bo[15:0]}, {1'b1, 1'b0, 1'b0, m0_addr_bi[15:0]});
      s_ack_i = 1;
      #1 check("rstw_tie_ack", {m1_ack_o, m0_ack_o}, 2'b01);
      $display("txn reset in WAIT_RESP, next tie granted to m0");
      tick();
      m0_req_i = 0; m1_req_i = 0; s_ack_i = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
